// File: rtl/bcd_converter.sv
// Double-dabble binary to BCD: one add-3/shift step per clock, 8 clocks from accepted start to done.
// Starts arriving while busy are dropped; displayed digits hold until the completion edge.
module bcd_converter (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bin,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] units
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [11:0] scr_q, scr_d, scr_adj;
  logic [7:0]  sh_q, sh_d;
  logic [3:0]  hun_q, hun_d;
  logic [3:0]  ten_q, ten_d;
  logic [3:0]  uni_q, uni_d;
  logic        done_q, done_d;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    scr_d   = scr_q;
    sh_d    = sh_q;
    hun_d   = hun_q;
    ten_d   = ten_q;
    uni_d   = uni_q;
    done_d  = 1'b0;
    scr_adj = {add3(scr_q[11:8]), add3(scr_q[7:4]), add3(scr_q[3:0])};

    case (state_q)
      IDLE: begin
        if (start) begin
          sh_d    = bin;
          scr_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Correction is applied before the shift so no nibble reaches 10 afterwards.
        scr_d = (scr_adj << 1) | {11'd0, sh_q[7]};
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          hun_d   = scr_d[11:8];
          ten_d   = scr_d[7:4];
          uni_d   = scr_d[3:0];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      scr_q   <= '0;
      sh_q    <= '0;
      hun_q   <= '0;
      ten_q   <= '0;
      uni_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scr_q   <= scr_d;
      sh_q    <= sh_d;
      hun_q   <= hun_d;
      ten_q   <= ten_d;
      uni_q   <= uni_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign hundreds = hun_q;
  assign tens     = ten_q;
  assign units    = uni_q;

endmodule

// File: tb/tb_bcd_converter.sv
// Directed bench for bcd_converter: vector table, multi-cycle corner sequences and a full 0..255 sweep.
module tb_bcd_converter;

  logic       clk;
  logic       rst;
  logic [7:0] bin;
  logic       start;
  logic       busy;
  logic       done;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] units;

  int total;
  int bad;

  bcd_converter dut (
    .clk      (clk),
    .rst      (rst),
    .bin      (bin),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .hundreds (hundreds),
    .tens     (tens),
    .units    (units)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] u;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Run one conversion. If imm is 0 the request is raised at the next negedge;
  // otherwise it is raised right now (used for the done-cycle back-to-back case).
  // Returns with the bench sitting at the negedge after the done edge.
  task automatic convert(input logic [7:0] v, input bit imm, input bit per_cycle, output int lat);
    logic [3:0] oh, ot, ou;
    int cyc;
    if (!imm) @(negedge clk);
    oh = hundreds; ot = tens; ou = units;
    bin   = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (per_cycle) begin
        chk("busy_during", {15'd0, busy}, 16'd1);
        chk("digits_hold", {4'd0, hundreds, tens, units}, {4'd0, oh, ot, ou});
      end
      @(negedge clk);
      cyc++;
    end
    lat = cyc;
    chk("done_vs_busy", {15'd0, busy}, 16'd0);
  endtask

  initial begin
    int lat;
    int ndone;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    bin   = 8'd0;

    vecs[0]  = '{8'd0,   4'd0, 4'd0, 4'd0};
    vecs[1]  = '{8'd255, 4'd2, 4'd5, 4'd5};
    vecs[2]  = '{8'd109, 4'd1, 4'd0, 4'd9};
    vecs[3]  = '{8'd99,  4'd0, 4'd9, 4'd9};
    vecs[4]  = '{8'd100, 4'd1, 4'd0, 4'd0};
    vecs[5]  = '{8'd10,  4'd0, 4'd1, 4'd0};
    vecs[6]  = '{8'd9,   4'd0, 4'd0, 4'd9};
    vecs[7]  = '{8'd199, 4'd1, 4'd9, 4'd9};
    vecs[8]  = '{8'd200, 4'd2, 4'd0, 4'd0};
    vecs[9]  = '{8'd128, 4'd1, 4'd2, 4'd8};
    vecs[10] = '{8'd64,  4'd0, 4'd6, 4'd4};
    vecs[11] = '{8'd85,  4'd0, 4'd8, 4'd5};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {15'd0, busy}, 16'd0);
    chk("reset_done", {15'd0, done}, 16'd0);
    chk("reset_digits", {4'd0, hundreds, tens, units}, 16'd0);

    foreach (vecs[i]) begin
      convert(vecs[i].b, 1'b0, 1'b1, lat);
      chk("vec_latency", lat[15:0], 16'd8);
      chk("vec_digits", {4'd0, hundreds, tens, units}, {4'd0, vecs[i].h, vecs[i].t, vecs[i].u});
      @(negedge clk);
      chk("vec_done_drop", {15'd0, done}, 16'd0);
    end

    // Back-to-back: second request raised in the done cycle of the first.
    convert(8'd109, 1'b0, 1'b0, lat);
    chk("b2b_first_lat", lat[15:0], 16'd8);
    chk("b2b_first", {4'd0, hundreds, tens, units}, 16'h0109);
    convert(8'd0, 1'b1, 1'b1, lat);
    chk("b2b_second_lat", lat[15:0], 16'd8);
    chk("b2b_second", {4'd0, hundreds, tens, units}, 16'h0000);

    // Start while busy is ignored and bin is not resampled.
    @(negedge clk);
    bin = 8'd99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin bin = 8'd200; start = 1'b1; end
      if (c == 4) start = 1'b0;
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        chk("ign_latency", c[15:0], 16'd8);
        chk("ign_digits", {4'd0, hundreds, tens, units}, 16'h0099);
      end
    end
    chk("ign_done_count", ndone[15:0], 16'd1);

    // Reset mid-conversion aborts without a done pulse.
    @(negedge clk);
    bin = 8'd250; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {15'd0, busy}, 16'd0);
    chk("abort_done", {15'd0, done}, 16'd0);
    chk("abort_digits", {4'd0, hundreds, tens, units}, 16'h0000);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone[15:0], 16'd0);
    convert(8'd7, 1'b0, 1'b1, lat);
    chk("after_abort_lat", lat[15:0], 16'd8);
    chk("after_abort_digits", {4'd0, hundreds, tens, units}, 16'h0007);

    // Exhaustive sweep against decimal arithmetic.
    for (int v = 0; v < 256; v++) begin
      int eh, et, eu;
      eh = v / 100;
      et = (v / 10) % 10;
      eu = v % 10;
      convert(v[7:0], 1'b0, 1'b0, lat);
      chk("sweep_latency", lat[15:0], 16'd8);
      chk("sweep_digits", {4'd0, hundreds, tens, units}, {4'd0, eh[3:0], et[3:0], eu[3:0]});
      chk("sweep_hund_hi", {14'd0, hundreds[3:2]}, 16'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
